// File: rtl/serial_sort_pkg.sv
// Shared types and sizing for the streaming odd-even transposition sorter.
// The SORT_IDX_EN macro adds arrival-position tags and the out_idx port.
package serial_sort_pkg;

  localparam int unsigned W = 8;
  localparam int unsigned N = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IW = idx_width(N);

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } sort_state_e;

endpackage

// File: rtl/serial_sort_stream_if.sv
// Input/output stream handshake bundle of serial_sort_stream.
// out_idx only exists when SORT_IDX_EN is defined.
interface serial_sort_stream_if;

  logic                                in_valid;
  logic [serial_sort_pkg::W-1:0]       in_data;
  logic                                in_ready;
  logic                                out_valid;
  logic [serial_sort_pkg::W-1:0]       out_data;
  logic                                out_last;
  logic                                out_ready;
`ifdef SORT_IDX_EN
  logic [serial_sort_pkg::IW-1:0]      out_idx;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef SORT_IDX_EN
    output out_idx,
`endif
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
`ifdef SORT_IDX_EN
    input  out_idx,
`endif
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/cas_cell.sv
// Combinational compare-exchange of two (word, tag) pairs; swaps only on strict
// greater so equal words keep arrival order. Tag ports exist with SORT_IDX_EN.
module cas_cell
  import serial_sort_pkg::*;
(
`ifdef SORT_IDX_EN
  input  logic [IW-1:0] a_t_i,
  input  logic [IW-1:0] b_t_i,
  output logic [IW-1:0] lo_t_o,
  output logic [IW-1:0] hi_t_o,
`endif
  input  logic [W-1:0]  a_w_i,
  input  logic [W-1:0]  b_w_i,
  output logic [W-1:0]  lo_w_o,
  output logic [W-1:0]  hi_w_o
);

  logic swap_c;

  assign swap_c = a_w_i > b_w_i;
  assign lo_w_o = swap_c ? b_w_i : a_w_i;
  assign hi_w_o = swap_c ? a_w_i : b_w_i;
`ifdef SORT_IDX_EN
  assign lo_t_o = swap_c ? b_t_i : a_t_i;
  assign hi_t_o = swap_c ? a_t_i : b_t_i;
`endif

endmodule

// File: rtl/serial_sort_stream.sv
// Loads N words, sorts them in place over N odd-even transposition phases,
// then drains them ascending. SORT_IDX_EN adds arrival tags and out_idx.
module serial_sort_stream
  import serial_sort_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  serial_sort_stream_if.slave  sort_if
);

  sort_state_e             state_q, state_d;
  logic [IW-1:0]           cnt_q, cnt_d;
  logic [N-1:0][W-1:0]     data_q, data_d, ev_w, od_w;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [W-1:0]            out_data_q, out_data_d;
  logic                    last_c, in_acc_c, out_acc_c;
`ifdef SORT_IDX_EN
  logic [N-1:0][IW-1:0]    tag_q, tag_d, ev_t, od_t;
  logic [IW-1:0]           out_idx_q, out_idx_d;
`endif

  assign last_c    = cnt_q == IW'(N - 1);
  assign in_acc_c  = sort_if.in_valid && in_ready_q;
  assign out_acc_c = sort_if.out_ready && out_valid_q;

  // Even phase: pairs (0,1),(2,3),...
  for (genvar i = 0; i < N / 2; i++) begin : g_even
    cas_cell u_cas (
`ifdef SORT_IDX_EN
      .a_t_i  (tag_q[2*i]),
      .b_t_i  (tag_q[2*i+1]),
      .lo_t_o (ev_t[2*i]),
      .hi_t_o (ev_t[2*i+1]),
`endif
      .a_w_i  (data_q[2*i]),
      .b_w_i  (data_q[2*i+1]),
      .lo_w_o (ev_w[2*i]),
      .hi_w_o (ev_w[2*i+1])
    );
  end

  // Odd phase: pairs (1,2),(3,4),...; the end words pass through.
  assign od_w[0]   = data_q[0];
  assign od_w[N-1] = data_q[N-1];
`ifdef SORT_IDX_EN
  assign od_t[0]   = tag_q[0];
  assign od_t[N-1] = tag_q[N-1];
`endif
  for (genvar i = 0; i < N / 2 - 1; i++) begin : g_odd
    cas_cell u_cas (
`ifdef SORT_IDX_EN
      .a_t_i  (tag_q[2*i+1]),
      .b_t_i  (tag_q[2*i+2]),
      .lo_t_o (od_t[2*i+1]),
      .hi_t_o (od_t[2*i+2]),
`endif
      .a_w_i  (data_q[2*i+1]),
      .b_w_i  (data_q[2*i+2]),
      .lo_w_o (od_w[2*i+1]),
      .hi_w_o (od_w[2*i+2])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef SORT_IDX_EN
    tag_d   = tag_q;
`endif
    unique case (state_q)
      LOAD: begin
        if (in_acc_c) begin
          data_d[cnt_q] = sort_if.in_data;
`ifdef SORT_IDX_EN
          tag_d[cnt_q]  = cnt_q;
`endif
          cnt_d = last_c ? '0 : cnt_q + IW'(1);
          if (last_c) state_d = SORT;
        end
      end
      SORT: begin
        data_d = cnt_q[0] ? od_w : ev_w;
`ifdef SORT_IDX_EN
        tag_d  = cnt_q[0] ? od_t : ev_t;
`endif
        cnt_d = last_c ? '0 : cnt_q + IW'(1);
        if (last_c) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_acc_c) begin
          cnt_d = last_c ? '0 : cnt_q + IW'(1);
          if (last_c) state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they never depend on inputs combinationally.
    in_ready_d  = state_d == LOAD;
    out_valid_d = state_d == DRAIN;
    out_last_d  = out_valid_d && (cnt_d == IW'(N - 1));
    out_data_d  = out_valid_d ? data_d[cnt_d] : '0;
`ifdef SORT_IDX_EN
    out_idx_d   = out_valid_d ? tag_d[cnt_d] : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
`ifdef SORT_IDX_EN
      tag_q       <= '0;
      out_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
`ifdef SORT_IDX_EN
      tag_q       <= tag_d;
      out_idx_q   <= out_idx_d;
`endif
    end
  end

  assign sort_if.in_ready  = in_ready_q;
  assign sort_if.out_valid = out_valid_q;
  assign sort_if.out_last  = out_last_q;
  assign sort_if.out_data  = out_data_q;
`ifdef SORT_IDX_EN
  assign sort_if.out_idx   = out_idx_q;
`endif

endmodule

// File: tb/tb_serial_sort_stream.sv
// Bench for serial_sort_stream: fixed frames, reset corner cases and random
// frames checked against a stable-sort reference model.
module tb_serial_sort_stream;
  import serial_sort_pkg::*;

  typedef logic [W-1:0] frame_t [N];
  typedef int           idx_t   [N];
  typedef struct {
    frame_t in_w;
    frame_t exp_w;
    idx_t   exp_i;
    int     mode;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   acc_cyc = 0;

  frame_t got_w;
  idx_t   got_i;
  logic   got_l [N];

  serial_sort_stream_if sif ();

  serial_sort_stream dut (
    .clk     (clk),
    .rst     (rst),
    .sort_if (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: stable insertion sort remembering each word's arrival slot.
  task automatic ref_sort(input frame_t w, output frame_t sw, output idx_t si);
    logic [W-1:0] tw;
    int           ti;
    for (int i = 0; i < N; i++) begin
      sw[i] = w[i];
      si[i] = i;
    end
    for (int i = 1; i < N; i++) begin
      for (int j = i; j > 0 && sw[j-1] > sw[j]; j--) begin
        tw = sw[j]; sw[j] = sw[j-1]; sw[j-1] = tw;
        ti = si[j]; si[j] = si[j-1]; si[j-1] = ti;
      end
    end
  endtask

  task automatic send_frame(input frame_t w, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      int t;
      t = 0;
      @(negedge clk);
      sif.in_valid = 1'b1;
      sif.in_data  = w[k];
      while (sif.in_ready !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        chk("in_ready_timeout", 0, 1);
        sif.in_valid = 1'b0;
        return;
      end
      acc_cyc = cyc;
      @(posedge clk);
      #1 sif.in_valid = 1'b0;
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1 per valid cycle, 2: random
  task automatic drain(input int mode, output int first_cyc);
    int           n, t, ph, bad_hold, bad_rdy;
    logic         stalled, rdy;
    logic [W-1:0] held;
    n = 0; t = 0; ph = 0; bad_hold = 0; bad_rdy = 0;
    stalled = 1'b0; held = '0;
    first_cyc = -1;
    while (n < N && t < 400) begin
      @(negedge clk);
      t++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (ph % 4 == 0) || (ph % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      sif.in_valid = 1'($urandom_range(0, 1));
      sif.in_data  = W'($urandom_range(0, 255));
      if (sif.out_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (stalled && sif.out_data !== held) bad_hold++;
        if (sif.in_ready !== 1'b0) bad_rdy++;
        ph++;
      end
      sif.out_ready = rdy;
      if (sif.out_valid === 1'b1 && rdy) begin
        got_w[n] = sif.out_data;
        got_l[n] = sif.out_last;
`ifdef SORT_IDX_EN
        got_i[n] = int'(sif.out_idx);
`endif
        n++;
        stalled = 1'b0;
      end else if (sif.out_valid === 1'b1) begin
        stalled = 1'b1;
        held    = sif.out_data;
      end
    end
    @(negedge clk);
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b0;
    chk("drain_count", n, N);
    chk("drain_hold_stable", bad_hold, 0);
    chk("drain_in_ready_low", bad_rdy, 0);
    chk("in_ready_after_drain", sif.in_ready, 1);
    chk("out_valid_after_drain", sif.out_valid, 0);
  endtask

  task automatic check_frame(input string name, input frame_t exp_w, input idx_t exp_i);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_data%0d", name, k), got_w[k], exp_w[k]);
      chk($sformatf("%s_last%0d", name, k), got_l[k], (k == N - 1) ? 1 : 0);
`ifdef SORT_IDX_EN
      chk($sformatf("%s_idx%0d", name, k), got_i[k], exp_i[k]);
`endif
    end
  endtask

  task automatic run_model_frame(input string name, input frame_t w, input int mode);
    frame_t sw;
    idx_t   si;
    int     first;
    ref_sort(w, sw, si);
    send_frame(w, N);
    drain(mode, first);
    check_frame(name, sw, si);
  endtask

  vec_t   vecs [4];
  frame_t fr;

  initial begin
    int first, dc, t, stray;
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b0;

    vecs[0].in_w  = '{7, 3, 9, 1, 8, 2, 6, 4};
    vecs[0].exp_w = '{1, 2, 3, 4, 6, 7, 8, 9};
    vecs[0].exp_i = '{3, 5, 1, 7, 6, 0, 4, 2};
    vecs[0].mode  = 0;
    vecs[1].in_w  = '{5, 5, 5, 0, 5, 5, 255, 5};
    vecs[1].exp_w = '{0, 5, 5, 5, 5, 5, 5, 255};
    vecs[1].exp_i = '{3, 0, 1, 2, 4, 5, 7, 6};
    vecs[1].mode  = 2;
    vecs[2].in_w  = '{255, 254, 253, 252, 251, 250, 249, 248};
    vecs[2].exp_w = '{248, 249, 250, 251, 252, 253, 254, 255};
    vecs[2].exp_i = '{7, 6, 5, 4, 3, 2, 1, 0};
    vecs[2].mode  = 0;
    vecs[3].in_w  = '{10, 200, 30, 30, 0, 99, 1, 7};
    vecs[3].exp_w = '{0, 1, 7, 10, 30, 30, 99, 200};
    vecs[3].exp_i = '{4, 6, 7, 0, 2, 3, 5, 1};
    vecs[3].mode  = 1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", sif.in_ready, 1);
    chk("rst_out_valid", sif.out_valid, 0);
    chk("rst_out_last", sif.out_last, 0);
    chk("rst_out_data", sif.out_data, 0);
`ifdef SORT_IDX_EN
    chk("rst_out_idx", sif.out_idx, 0);
`endif
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].in_w, N);
      drain(vecs[v].mode, first);
      chk($sformatf("vec%0d_latency", v), first - acc_cyc, N + 1);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_w, vecs[v].exp_i);
    end

    // Partial frame abandoned by reset.
    fr = '{9, 9, 9, 9, 9, 9, 9, 9};
    send_frame(fr, 5);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("partial_rst_in_ready", sif.in_ready, 1);
    chk("partial_rst_out_valid", sif.out_valid, 0);
    fr = '{40, 12, 200, 3, 77, 12, 0, 150};
    run_model_frame("after_partial", fr, 0);

    // Reset on the third DRAIN cycle.
    fr = '{8, 6, 4, 2, 7, 5, 3, 1};
    send_frame(fr, N);
    sif.out_ready = 1'b1;
    dc = 0; t = 0;
    while (dc < 3 && t < 100) begin
      @(negedge clk);
      t++;
      if (sif.out_valid === 1'b1) dc++;
    end
    chk("drain_rst_reached", dc, 3);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("drain_rst_out_valid", sif.out_valid, 0);
    chk("drain_rst_in_ready", sif.in_ready, 1);
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (sif.out_valid !== 1'b0) stray++;
    end
    chk("drain_rst_no_stray_out", stray, 0);
    sif.out_ready = 1'b0;
    fr = '{100, 50, 150, 25, 125, 75, 175, 0};
    run_model_frame("after_drain_rst", fr, 2);

    // Random frames, half of them drawn from a tiny range to force ties.
    for (int f = 0; f < 16; f++) begin
      for (int k = 0; k < N; k++)
        fr[k] = (f % 2 == 1) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 255));
      run_model_frame($sformatf("rand%0d", f), fr, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
